pipe_stage_reg: RTL and testbench

Generic parametrised pipeline-stage register, successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque WIDTH-bit payload with a valid/ready handshake, flush, and an optional 2-entry skid buffer.
- Gives full-throughput backpressure without a combinational ready path.
- Instantiated between every pair of core pipeline stages; callers pack and unpack fields.

---
 rtl/pipe_pkg.sv | 61 ++++++
 rtl/pipe_slot.sv | 52 +++++
 rtl/pipe_stage_reg.sv | 158 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the inter-stage pipeline registers: skid FSM states, occupancy width,
// and the default packed payload layouts that callers flatten into pipe_stage_reg.
package pipe_pkg;

    localparam int OCC_W = 2;
    localparam int XLEN  = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } if_id_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [3:0]      alu_op;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
    } id_ex_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] store_data;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
    } ex_mem_t;

    typedef struct packed {
        logic [XLEN-1:0] wb_data;
        logic [4:0]      rd;
        logic            reg_write;
    } mem_wb_t;

    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

    function automatic logic [OCC_W-1:0] occ_of(input pipe_state_e s);
        case (s)
            ONE:     occ_of = 2'd1;
            TWO:     occ_of = 2'd2;
            default: occ_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage: valid bit plus payload register.
// With PIPE_BUBBLE_ZERO_EN defined, a slot going invalid also zeroes its payload.
module pipe_slot #(
    parameter int WIDTH = 160
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // flush beats load so a payload accepted during a redirect is dropped
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
`ifdef PIPE_BUBBLE_ZERO_EN
            data_d  = '0;
`endif
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
`ifdef PIPE_BUBBLE_ZERO_EN
            data_d  = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register with flush, optional 2-entry skid (SKID=1) and stall counter.
// Build option PIPE_BUBBLE_ZERO_EN (in pipe_slot) zeroes payloads of slots that go invalid.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = 160,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occ,
    output logic             init_done,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             accept, drain;
    logic             main_load, main_clr;
    logic [WIDTH-1:0] main_din;
    logic             main_valid;
    logic [WIDTH-1:0] main_data;

    assign accept = in_valid & in_ready;
    assign drain  = main_valid & out_ready;

    pipe_slot #(.WIDTH(WIDTH)) u_main (
        .clk     (clk),
        .reset   (reset),
        .load_i  (main_load),
        .clear_i (main_clr),
        .flush_i (flush),
        .data_i  (main_din),
        .valid_o (main_valid),
        .data_o  (main_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_state_e      state_q;
            logic             in_ready_q;
            logic             skid_load, skid_clr;
            logic             skid_valid;
            logic [WIDTH-1:0] skid_data;

            // State | Meaning
            // EMPTY | nothing held, main invalid
            // ONE   | main holds the only entry
            // TWO   | main holds older entry, skid the newer; upstream blocked
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    state_q    <= EMPTY;
                    in_ready_q <= 1'b1;
                end else if (flush) begin
                    state_q    <= EMPTY;
                    in_ready_q <= 1'b1;
                end else begin
                    case (state_q)
                        EMPTY: if (accept) state_q <= ONE;
                        ONE: begin
                            if (accept && !drain) begin
                                state_q    <= TWO;
                                in_ready_q <= 1'b0;
                            end else if (!accept && drain) begin
                                state_q    <= EMPTY;
                            end
                        end
                        TWO: begin
                            if (drain) begin
                                state_q    <= ONE;
                                in_ready_q <= 1'b1;
                            end
                        end
                        default: begin
                            state_q    <= EMPTY;
                            in_ready_q <= 1'b1;
                        end
                    endcase
                end
            end

            always_comb begin
                main_load = 1'b0;
                main_clr  = 1'b0;
                skid_load = 1'b0;
                skid_clr  = 1'b0;
                main_din  = in_data;
                case (state_q)
                    EMPTY: main_load = accept;
                    ONE: begin
                        main_load = accept & drain;
                        skid_load = accept & ~drain;
                        main_clr  = drain & ~accept;
                    end
                    TWO: begin
                        // skid entry is younger, so it moves up into main on drain
                        main_load = drain;
                        main_din  = skid_data;
                        skid_clr  = drain;
                    end
                    default: ;
                endcase
            end

            pipe_slot #(.WIDTH(WIDTH)) u_skid (
                .clk     (clk),
                .reset   (reset),
                .load_i  (skid_load),
                .clear_i (skid_clr),
                .flush_i (flush),
                .data_i  (in_data),
                .valid_o (skid_valid),
                .data_o  (skid_data)
            );

            assign in_ready = in_ready_q;
            assign occ      = occ_of(state_q);
        end else begin : g_single
            // gated by reset so upstream sees not-ready while the stage is held in reset
            assign in_ready  = reset & (out_ready | ~main_valid);
            assign main_load = accept;
            assign main_clr  = drain & ~accept;
            assign main_din  = in_data;
            assign occ       = {1'b0, main_valid};
        end
    endgenerate

    logic [CNT_W-1:0] stall_q, stall_d;
    logic             init_q;

    always_comb begin
        stall_d = stall_q;
        if (main_valid && !out_ready && (stall_q != '1))
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            init_q  <= 1'b0;
        end else begin
            stall_q <= stall_d;
            init_q  <= 1'b1;
        end
    end

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign stall_cnt = stall_q;
    assign init_done = init_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 and a SKID=0 instance, each against a FIFO-queue reference.
module tb_pipe_stage_reg;

    localparam int W   = 16;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;

    logic          iv1, or1, fl1, ir1, ov1, idn1;
    logic [W-1:0]  id1, od1;
    logic [1:0]    occ1;
    logic [CW-1:0] sc1;

    logic          iv0, or0, fl0, ir0, ov0, idn0;
    logic [W-1:0]  id0, od0;
    logic [1:0]    occ0;
    logic [CW-1:0] sc0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(W), .SKID(1), .CNT_W(CW)) u_dut1 (
        .clk(clk), .reset(rst_n),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1), .flush(fl1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .occ(occ1), .init_done(idn1), .stall_cnt(sc1)
    );

    pipe_stage_reg #(.WIDTH(W), .SKID(0), .CNT_W(CW)) u_dut0 (
        .clk(clk), .reset(rst_n),
        .in_valid(iv0), .in_ready(ir0), .in_data(id0), .flush(fl0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0),
        .occ(occ0), .init_done(idn0), .stall_cnt(sc0)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference: each stage is a FIFO of capacity 2 (skid) or 1 (single)
    logic [W-1:0] q1[$];
    logic [W-1:0] q0[$];
    int  stall1 = 0;
    int  stall0 = 0;
    bit  init_exp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_rdy1();
        return !rst_n ? 1'b1 : (q1.size() < 2);
    endfunction

    function automatic bit exp_rdy0();
        return rst_n && (or0 || q0.size() == 0);
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ":ir1"},  32'(ir1),  32'(exp_rdy1()));
        chk({tag, ":ov1"},  32'(ov1),  32'(q1.size() != 0));
        chk({tag, ":occ1"}, 32'(occ1), 32'(q1.size()));
        chk({tag, ":sc1"},  32'(sc1),  32'(stall1));
        chk({tag, ":id1"},  32'(idn1), 32'(init_exp));
        if (q1.size() != 0) chk({tag, ":od1"}, 32'(od1), 32'(q1[0]));
`ifdef PIPE_BUBBLE_ZERO_EN
        else chk({tag, ":od1z"}, 32'(od1), 32'd0);
`endif
        chk({tag, ":ir0"},  32'(ir0),  32'(exp_rdy0()));
        chk({tag, ":ov0"},  32'(ov0),  32'(q0.size() != 0));
        chk({tag, ":occ0"}, 32'(occ0), 32'(q0.size()));
        chk({tag, ":sc0"},  32'(sc0),  32'(stall0));
        chk({tag, ":id0"},  32'(idn0), 32'(init_exp));
        if (q0.size() != 0) chk({tag, ":od0"}, 32'(od0), 32'(q0[0]));
`ifdef PIPE_BUBBLE_ZERO_EN
        else chk({tag, ":od0z"}, 32'(od0), 32'd0);
`endif
    endtask

    // called at posedge+1 after inputs are set; returns at the next posedge+1
    task automatic tick(input string tag);
        bit acc1, drn1, st1, acc0, drn0, st0;
        #1;
        check_all(tag);
        acc1 = iv1 && exp_rdy1();
        drn1 = (q1.size() != 0) && or1;
        st1  = (q1.size() != 0) && !or1;
        acc0 = iv0 && exp_rdy0();
        drn0 = (q0.size() != 0) && or0;
        st0  = (q0.size() != 0) && !or0;
        @(posedge clk);
        if (st1 && stall1 < SAT) stall1++;
        if (st0 && stall0 < SAT) stall0++;
        if (fl1) q1.delete();
        else begin
            if (drn1) void'(q1.pop_front());
            if (acc1) q1.push_back(id1);
        end
        if (fl0) q0.delete();
        else begin
            if (drn0) void'(q0.pop_front());
            if (acc0) q0.push_back(id0);
        end
        init_exp = 1'b1;
        #1;
    endtask

    task automatic idle(input int n);
        iv1 = 0; fl1 = 0; or1 = 1;
        iv0 = 0; fl0 = 0; or0 = 1;
        for (int k = 0; k < n; k++) tick("idle");
    endtask

    initial begin
        rst_n = 1'b1;
        iv1 = 0; or1 = 0; fl1 = 0; id1 = '0;
        iv0 = 0; or0 = 0; fl0 = 0; id0 = '0;
        #1 rst_n = 1'b0;
        #1;
        check_all("reset");
        chk("reset:od1", 32'(od1), 32'd0);
        chk("reset:od0", 32'(od0), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1 check_all("release");
        @(posedge clk);
        init_exp = 1'b1;
        #1;

        // streaming at full rate
        or1 = 1; or0 = 1;
        for (int k = 1; k <= 3; k++) begin
            iv1 = 1; id1 = W'(k);
            iv0 = 1; id0 = W'(k);
            tick("stream");
        end
        idle(2);

        // bubble after draining with no refill
        iv1 = 1; id1 = 16'hDEAD; iv0 = 1; id0 = 16'hDEAD;
        tick("bub_load");
        iv1 = 0; iv0 = 0;
        tick("bub_drain");
        #1;
`ifdef PIPE_BUBBLE_ZERO_EN
        chk("bubble1", 32'(od1), 32'd0);
        chk("bubble0", 32'(od0), 32'd0);
`else
        chk("bubble1", 32'(od1), 32'hDEAD);
        chk("bubble0", 32'(od0), 32'hDEAD);
`endif
        chk("bubble_v1", 32'(ov1), 32'd0);
        #0;
        @(posedge clk);
        #1;

        // flush with a simultaneous accept while full
        or1 = 0; iv1 = 1; id1 = 16'h5; tick("fl_fill");
        id1 = 16'h6; tick("fl_fill");
        fl1 = 1; id1 = 16'h7; fl0 = 1; iv0 = 1; id0 = 16'h7; tick("flush");
        chk("flush_ov1",  32'(ov1),  32'd0);
        chk("flush_occ1", 32'(occ1), 32'd0);
        fl1 = 0; fl0 = 0; iv1 = 0; iv0 = 0; or1 = 1;
        tick("post_flush");
        idle(1);

        // backpressure on the skid stage long enough to saturate stall_cnt
        or1 = 0;
        iv1 = 1; id1 = 16'hA; tick("bp");
        id1 = 16'hB; tick("bp");
        id1 = 16'hC;
        for (int k = 0; k < 18; k++) tick("bp_hold");
        chk("bp_sat", 32'(sc1), 32'(SAT));
        or1 = 1;
        tick("bp_rel");
        tick("bp_rel");
        iv1 = 0;
        idle(3);

        // single-slot: in_ready follows out_ready combinationally
        iv0 = 1;
        for (int k = 0; k < 8; k++) begin
            id0 = W'(16'h100 + k);
            or0 = k[0];
            tick("comb_rdy");
        end

        // async reset mid-stall
        or1 = 0; or0 = 0; iv1 = 1; iv0 = 1;
        id1 = 16'h21; id0 = 16'h31; tick("pre_rst");
        id1 = 16'h22; tick("pre_rst");
        iv1 = 0; iv0 = 0;
        #2 rst_n = 1'b0;
        #1;
        q1.delete(); q0.delete();
        stall1 = 0; stall0 = 0; init_exp = 1'b0;
        check_all("mid_rst");
        #2 rst_n = 1'b1;
        #1 check_all("rst_rel");
        @(posedge clk);
        init_exp = 1'b1;
        #1;

        // randomized traffic on both stages
        for (int k = 0; k < 300; k++) begin
            iv1 = ($urandom_range(0, 3) != 0); id1 = W'($urandom);
            or1 = ($urandom_range(0, 3) != 0); fl1 = ($urandom_range(0, 15) == 0);
            iv0 = ($urandom_range(0, 3) != 0); id0 = W'($urandom);
            or0 = ($urandom_range(0, 3) != 0); fl0 = ($urandom_range(0, 15) == 0);
            tick("rand");
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
